// File: rtl/digital_clock_pkg.sv
// Shared constants and types for the minutes:seconds timekeeper.
// No ports; imported by digital_clock_mmss and mod_n_counter.
package digital_clock_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;
    localparam int unsigned HR_W    = 5;

    typedef logic [5:0] cnt6_t;

endpackage : digital_clock_pkg

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with a combinational wrap strobe.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high clear
//   inc    - advance by one this cycle
//   value  - current count, 0..N-1
//   wrap   - inc && value==N-1 (count returns to 0 on this edge)
module mod_n_counter
    import digital_clock_pkg::*;
#(
    parameter int unsigned N = 60,
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = inc && (value == LAST);

    // Count register: reset wins, then wrap-to-zero, then increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + W'(1);
        end
    end

endmodule : mod_n_counter

// File: rtl/digital_clock_mmss.sv
// Free-running minutes:seconds timekeeper with a clock prescaler.
// Optional macro DIGITAL_CLOCK_HOURS_EN adds a 0..23 hours counter.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   seconds    - binary 0..59
//   minutes    - binary 0..59
//   min_carry  - registered pulse, cycle after seconds wraps 59->0
//   hour_carry - registered pulse, cycle after minutes wraps 59->0
//   hours      - binary 0..23 (only with DIGITAL_CLOCK_HOURS_EN)
module digital_clock_mmss
    import digital_clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned CNT_W         = 6
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] seconds,
    output logic [CNT_W-1:0] minutes,
    output logic             min_carry,
    output logic             hour_carry
`ifdef DIGITAL_CLOCK_HOURS_EN
    ,
    output logic [HR_W-1:0]  hours
`endif
);

    localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    // Prescaler phase is only observed through its wrap (the second tick).
    logic [PRE_W-1:0] pre_count_unused;
    logic             sec_tick;
    logic             sec_wrap;
    logic             min_wrap;

    mod_n_counter #(.N(TICKS_PER_SEC), .W(PRE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .value (pre_count_unused),
        .wrap  (sec_tick)
    );

    mod_n_counter #(.N(SEC_MAX + 1), .W(CNT_W)) u_seconds (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_tick),
        .value (seconds),
        .wrap  (sec_wrap)
    );

    // Minutes advance on the same edge seconds wraps, so 60 is never visible.
    mod_n_counter #(.N(MIN_MAX + 1), .W(CNT_W)) u_minutes (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_wrap),
        .value (minutes),
        .wrap  (min_wrap)
    );

`ifdef DIGITAL_CLOCK_HOURS_EN
    logic hr_wrap_unused;

    mod_n_counter #(.N(HR_MAX + 1), .W(HR_W)) u_hours (
        .clk   (clk),
        .reset (reset),
        .inc   (min_wrap),
        .value (hours),
        .wrap  (hr_wrap_unused)
    );
`endif

    // Carry pulses are the wrap strobes delayed by one register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_carry  <= 1'b0;
            hour_carry <= 1'b0;
        end else begin
            min_carry  <= sec_wrap;
            hour_carry <= min_wrap;
        end
    end

endmodule : digital_clock_mmss

// File: tb/tb_digital_clock_mmss.sv
// Self-checking bench: one DUT at 1 tick/s, one at 4 ticks/s, both against
// a behavioural reference model via a per-DUT expected-value queue.
module tb_digital_clock_mmss;

    typedef struct packed {
        logic [31:0] pre;
        logic [31:0] sec;
        logic [31:0] mn;
        logic [31:0] hr;
        logic        mc;
        logic        hc;
    } st_t;

    logic       clk = 1'b0;
    logic       rst1;
    logic       rst4;
    logic [5:0] sec1, min1, sec4, min4;
    logic       mc1, hc1, mc4, hc4;
`ifdef DIGITAL_CLOCK_HOURS_EN
    logic [4:0] hr1, hr4;
`endif

    int  total = 0;
    int  bad   = 0;
    st_t m1 = '0;
    st_t m4 = '0;
    st_t q1[$];
    st_t q4[$];

    always #5 clk = ~clk;

    digital_clock_mmss #(.TICKS_PER_SEC(1), .CNT_W(6)) dut1 (
        .clk        (clk),
        .reset      (rst1),
        .seconds    (sec1),
        .minutes    (min1),
        .min_carry  (mc1),
        .hour_carry (hc1)
`ifdef DIGITAL_CLOCK_HOURS_EN
        ,
        .hours      (hr1)
`endif
    );

    digital_clock_mmss #(.TICKS_PER_SEC(4), .CNT_W(6)) dut4 (
        .clk        (clk),
        .reset      (rst4),
        .seconds    (sec4),
        .minutes    (min4),
        .min_carry  (mc4),
        .hour_carry (hc4)
`ifdef DIGITAL_CLOCK_HOURS_EN
        ,
        .hours      (hr4)
`endif
    );

    // Reference model: state after one rising edge.
    function automatic st_t nxt(st_t s, logic r, int unsigned t);
        st_t n;
        n    = s;
        n.mc = 1'b0;
        n.hc = 1'b0;
        if (r) begin
            n = '0;
        end else if (s.pre == 32'(t - 1)) begin
            n.pre = 32'd0;
            if (s.sec == 32'd59) begin
                n.sec = 32'd0;
                n.mc  = 1'b1;
                if (s.mn == 32'd59) begin
                    n.mn = 32'd0;
                    n.hc = 1'b1;
                    n.hr = (s.hr == 32'd23) ? 32'd0 : s.hr + 32'd1;
                end else begin
                    n.mn = s.mn + 32'd1;
                end
            end else begin
                n.sec = s.sec + 32'd1;
            end
        end else begin
            n.pre = s.pre + 32'd1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance model, queue expectations, then compare #1 later.
    task automatic cyc();
        st_t e;
        @(posedge clk);
        m1 = nxt(m1, rst1, 1);
        m4 = nxt(m4, rst4, 4);
        q1.push_back(m1);
        q4.push_back(m4);
        #1;
        e = q1.pop_front();
        chk("d1_sec", 32'(sec1), e.sec);
        chk("d1_min", 32'(min1), e.mn);
        chk("d1_mc",  32'(mc1),  32'(e.mc));
        chk("d1_hc",  32'(hc1),  32'(e.hc));
        chk("d1_range", 32'((sec1 <= 6'd59) && (min1 <= 6'd59)), 32'd1);
`ifdef DIGITAL_CLOCK_HOURS_EN
        chk("d1_hr",  32'(hr1),  e.hr);
`endif
        e = q4.pop_front();
        chk("d4_sec", 32'(sec4), e.sec);
        chk("d4_min", 32'(min4), e.mn);
        chk("d4_mc",  32'(mc4),  32'(e.mc));
        chk("d4_hc",  32'(hc4),  32'(e.hc));
        chk("d4_range", 32'((sec4 <= 6'd59) && (min4 <= 6'd59)), 32'd1);
`ifdef DIGITAL_CLOCK_HOURS_EN
        chk("d4_hr",  32'(hr4),  e.hr);
`endif
    endtask

    initial begin
        // Reset both for two cycles.
        rst1 = 1'b1;
        rst4 = 1'b1;
        cyc();
        cyc();
        chk("rst_sec", 32'(sec1), 32'd0);
        chk("rst_min", 32'(min1), 32'd0);
        chk("rst_mc",  32'(mc1),  32'd0);
        chk("rst_hc",  32'(hc1),  32'd0);
        chk("rst4_sec", 32'(sec4), 32'd0);

        // Release: 1 tick/s advances at once, 4 ticks/s on the 4th edge.
        rst1 = 1'b0;
        rst4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 1) chk("first_tick", 32'(sec1), 32'd1);
            chk("d4_latency", 32'(sec4), (i == 4) ? 32'd1 : 32'd0);
        end

        // Up to 00:59, then the minute rollover.
        for (int i = 0; i < 55; i++) cyc();
        chk("at59_sec", 32'(sec1), 32'd59);
        chk("at59_min", 32'(min1), 32'd0);
        cyc();
        chk("roll_sec", 32'(sec1), 32'd0);
        chk("roll_min", 32'(min1), 32'd1);
        chk("roll_mc",  32'(mc1),  32'd1);
        cyc();
        chk("roll_mc_drop", 32'(mc1), 32'd0);

        // Tick 3599 from reset is 59:59; tick 3600 is the full wrap.
        for (int i = 0; i < 3538; i++) cyc();
        chk("end_sec", 32'(sec1), 32'd59);
        chk("end_min", 32'(min1), 32'd59);
        cyc();
        chk("wrap_sec", 32'(sec1), 32'd0);
        chk("wrap_min", 32'(min1), 32'd0);
        chk("wrap_mc",  32'(mc1),  32'd1);
        chk("wrap_hc",  32'(hc1),  32'd1);
`ifdef DIGITAL_CLOCK_HOURS_EN
        chk("wrap_hr",  32'(hr1),  32'd1);
`endif
        cyc();
        chk("wrap_hc_drop", 32'(hc1), 32'd0);

        // Restart, count to 12:34, reset mid-count, resume.
        rst1 = 1'b1;
        cyc();
        rst1 = 1'b0;
        for (int i = 0; i < 754; i++) cyc();
        chk("t1234_sec", 32'(sec1), 32'd34);
        chk("t1234_min", 32'(min1), 32'd12);
        rst1 = 1'b1;
        cyc();
        chk("midrst_sec", 32'(sec1), 32'd0);
        chk("midrst_min", 32'(min1), 32'd0);
        rst1 = 1'b0;
        cyc();
        chk("resume_sec", 32'(sec1), 32'd1);

        // Slow clock: reset while prescaler phase is 2 restarts the phase.
        for (int i = 0; i < 8 && m4.pre != 32'd2; i++) cyc();
        rst4 = 1'b1;
        cyc();
        chk("d4_rst_sec", 32'(sec4), 32'd0);
        rst4 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("d4_phase", 32'(sec4), (i >= 4) ? 32'd1 : 32'd0);
        end

        // Long run with occasional random resets, model-checked every cycle.
        for (int i = 0; i < 10000; i++) begin
            rst1 = ($urandom_range(0, 2999) == 0);
            rst4 = ($urandom_range(0, 2999) == 0);
            cyc();
        end
        rst1 = 1'b0;
        rst4 = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_digital_clock_mmss
